// File: rtl/sdm_decim_comb_if.sv
// Output stream of the decimating comb: sample data with a valid/ready handshake.
interface sdm_decim_comb_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/sdm_decim_comb.sv
// First-order (optionally second-order) decimating comb behind the iCESDM up/down counter,
// with a 2-entry output buffer. Define SDM_COMB_SECOND_STAGE_EN to add the second comb.
module sdm_decim_comb #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [WIDTH-1:0]     i_count,
  output logic                 o_overrun,
  sdm_decim_comb_if.master     m_out
);

  if (DECIM_LOG2 < 1 || DECIM_LOG2 + 3 > WIDTH) begin : g_param_check
    $error("sdm_decim_comb: DECIM_LOG2 must be in 1..WIDTH-3");
  end

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    RUN    = 2'd2
  } state_t;

`ifdef SDM_COMB_SECOND_STAGE_EN
  localparam state_t AFTER_PRIME0 = PRIME1;
`else
  localparam state_t AFTER_PRIME0 = RUN;
`endif

  logic [DECIM_LOG2-1:0] phase_q;
  logic [WIDTH-1:0]      prev1_q;
  logic [WIDTH-1:0]      diff1_c;
  logic [WIDTH-1:0]      result_c;
  logic                  strobe_c;
  logic                  push_c;
  logic                  pop_c;
  state_t                state_q, state_d;

  logic [WIDTH-1:0]      head_q, tail_q;
  logic                  head_vld_q, tail_vld_q;
  logic                  overrun_q;

  assign strobe_c = i_en & (&phase_q);
  assign diff1_c  = i_count - prev1_q;
  assign pop_c    = head_vld_q & m_out.i_ready;

  // Decimation phase: one strobe every 2^DECIM_LOG2 enabled cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q <= '0;
    end else if (i_en) begin
      phase_q <= phase_q + DECIM_LOG2'(1);
    end
  end

  // Previous integrator sample; modular subtraction makes counter wrap transparent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev1_q <= '0;
    end else if (strobe_c) begin
      prev1_q <= i_count;
    end
  end

`ifdef SDM_COMB_SECOND_STAGE_EN
  logic [WIDTH-1:0] prev2_q;
  logic             load_prev2_c;

  assign load_prev2_c = strobe_c & (state_q != PRIME0);
  assign result_c     = diff1_c - prev2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev2_q <= '0;
    end else if (load_prev2_c) begin
      prev2_q <= diff1_c;
    end
  end
`else
  assign result_c = diff1_c;
`endif

  // Priming state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PRIME0;
    end else begin
      state_q <= state_d;
    end
  end

  // Priming sequence: history registers must be filled before results are meaningful.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    if (strobe_c) begin
      case (state_q)
        PRIME0:  state_d = AFTER_PRIME0;
        PRIME1:  state_d = RUN;
        RUN:     push_c  = 1'b1;
        default: state_d = PRIME0;
      endcase
    end
  end

  // Two-entry buffer: head drives o_data directly, tail holds the second sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (!head_vld_q) begin
      if (push_c) begin
        head_q     <= result_c;
        head_vld_q <= 1'b1;
      end
    end else if (!tail_vld_q) begin
      if (push_c && pop_c) begin
        head_q <= result_c;
      end else if (push_c) begin
        tail_q     <= result_c;
        tail_vld_q <= 1'b1;
      end else if (pop_c) begin
        head_vld_q <= 1'b0;
      end
    end else begin
      if (pop_c) begin
        head_q <= tail_q;
        if (push_c) begin
          tail_q <= result_c;
        end else begin
          tail_vld_q <= 1'b0;
        end
      end else if (push_c) begin
        // Full with no drain this cycle: drop the new sample and flag it until reset.
        overrun_q <= 1'b1;
      end
    end
  end

  assign m_out.o_data  = head_q;
  assign m_out.o_valid = head_vld_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_sdm_decim_comb.sv
// Self-checking bench for sdm_decim_comb (WIDTH=8, R=4): queue-based reference model plus directed vectors.
module tb_sdm_decim_comb;

  localparam int unsigned W  = 8;
  localparam int unsigned DL = 2;
  localparam int          R  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] cnt;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  sdm_decim_comb_if #(.WIDTH(W)) bus ();

  sdm_decim_comb #(.WIDTH(W), .DECIM_LOG2(DL)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_count   (cnt),
    .o_overrun (overrun),
    .m_out     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every R-th enabled cycle is a sample; outputs are differences of samples.
  logic [W-1:0] q[$];
  logic         m_ovr = 1'b0;
  logic         armed = 1'b0;
  int           en_cycles, nsamp;
  logic [W-1:0] last_cnt, last_d, d, val;

  always @(posedge clk) begin
    logic pop, do_push;
    int   pre;
    armed = 1'b1;
    if (rst) begin
      q.delete();
      m_ovr     = 1'b0;
      en_cycles = 0;
      nsamp     = 0;
      last_cnt  = '0;
      last_d    = '0;
    end else begin
      pop     = (q.size() != 0) && bus.i_ready;
      do_push = 1'b0;
      if (en) begin
        if (en_cycles % R == R - 1) begin
          d = cnt - last_cnt;
`ifdef SDM_COMB_SECOND_STAGE_EN
          if (nsamp >= 2) begin
            val     = d - last_d;
            do_push = 1'b1;
          end
          if (nsamp >= 1) last_d = d;
`else
          if (nsamp >= 1) begin
            val     = d;
            do_push = 1'b1;
          end
`endif
          last_cnt = cnt;
          nsamp++;
        end
        en_cycles++;
      end
      pre = q.size();
      if (pop) void'(q.pop_front());
      if (do_push) begin
        if (pre < 2 || pop) q.push_back(val);
        else m_ovr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid", {31'd0, bus.o_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("data", {24'd0, bus.o_data}, {24'd0, q[0]});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    end
  end

  task automatic cyc(input logic r, input logic e, input logic rd, input logic [W-1:0] c);
    rst         = r;
    en          = e;
    bus.i_ready = rd;
    cnt         = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b1, '0);
  endtask

  initial begin
    int first, nvalid;
    rst         = 1'b1;
    en          = 1'b0;
    bus.i_ready = 1'b0;
    cnt         = '0;
    do_reset();
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.o_data}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);

`ifndef SDM_COMB_SECOND_STAGE_EN
    // Incrementing count: +4 per output, first output on the 2nd strobe (edge 7).
    first = -1; nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b1, W'(i));
      if (bus.o_valid) begin
        nvalid++;
        chk("t1_data", {24'd0, bus.o_data}, 32'h04);
        if (first < 0) first = i;
      end
    end
    chk("t1_first", first, 32'd7);
    chk("t1_nvalid", nvalid, 32'd4);
    chk("t1_ovr", {31'd0, overrun}, 32'd0);

    // Decrementing through the 0x00 -> 0xFF wrap: constant -4.
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b1, W'(3 - i));
      if (bus.o_valid) begin
        nvalid++;
        chk("t2_data", {24'd0, bus.o_data}, 32'hFC);
      end
    end
    chk("t2_nvalid", nvalid, 32'd3);

    // Stalled sink across three RUN strobes: 0x28, 0x48 kept, 0x68 dropped.
    do_reset();
    for (int i = 0; i <= 16; i++) cyc(1'b0, 1'b1, 1'b0, W'(i * i));
    chk("t3_valid0", {31'd0, bus.o_valid}, 32'd1);
    chk("t3_head0", {24'd0, bus.o_data}, 32'h28);
    chk("t3_ovr0", {31'd0, overrun}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("t3_valid1", {31'd0, bus.o_valid}, 32'd1);
    chk("t3_head1", {24'd0, bus.o_data}, 32'h48);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("t3_empty", {31'd0, bus.o_valid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("t3_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Enable toggling every cycle: strobes every 8 clocks, delta 0x08.
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'((i % 2) == 0), 1'b1, W'(i));
      if (bus.o_valid) begin
        nvalid++;
        chk("t4_data", {24'd0, bus.o_data}, 32'h08);
      end
    end
    chk("t4_nvalid", nvalid, 32'd3);

    // Reset mid-run with one buffered entry, then re-prime.
    do_reset();
    for (int i = 0; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, W'(i));
    chk("t5_buffered", {31'd0, bus.o_valid}, 32'd1);
    chk("t5_buf_data", {24'd0, bus.o_data}, 32'h04);
    cyc(1'b1, 1'b1, 1'b0, 8'd9);
    chk("t5_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("t5_rst_data", {24'd0, bus.o_data}, 32'd0);
    chk("t5_rst_ovr", {31'd0, overrun}, 32'd0);
    first = -1; nvalid = 0;
    for (int i = 10; i < 26; i++) begin
      cyc(1'b0, 1'b1, 1'b1, W'(i));
      if (bus.o_valid) begin
        nvalid++;
        chk("t5_data", {24'd0, bus.o_data}, 32'h04);
        if (first < 0) first = i;
      end
    end
    chk("t5_first", first, 32'd17);
    chk("t5_nvalid", nvalid, 32'd3);
`else
    // Triangular count: constant second difference 0x10 after two priming strobes.
    first = -1; nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, 1'b1, W'(i * (i + 1) / 2));
      if (bus.o_valid) begin
        nvalid++;
        chk("t6_data", {24'd0, bus.o_data}, 32'h10);
        if (first < 0) first = i;
      end
    end
    chk("t6_first", first, 32'd11);
    chk("t6_nvalid", nvalid, 32'd4);
    chk("t6_ovr", {31'd0, overrun}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
